// File: rtl/proc_pkg.sv
// Shared opcode and state definitions for the 8-bit processor control path.
package proc_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag; bounds the wait for dm_ready in MEM.
module seq_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout
// and a saturating retired-instruction counter.
module control_sequencer
    import proc_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int RETIRE_W    = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                dm_ready,
    output logic                pc_en,
    output logic                ir_load,
    output logic                alu_en,
    output logic                dm_read,
    output logic                dm_write,
    output logic                rf_write,
    output logic                wb_sel,
    output logic [2:0]          state,
    output logic                halted,
    output logic                err_illegal,
    output logic                err_timeout,
    output logic [RETIRE_W-1:0] retired
);

    localparam int TMR_W =
        (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    seq_state_t          state_q;
    seq_state_t          nxt;
    logic [OPCODE_W-1:0] op_q;
    logic                dec_alu;
    logic                dec_mem;
    logic                dec_nop;
    logic                dec_halt;
    logic                q_load;
    logic                q_store;
    logic                go_fetch;
    logic                ill;
    logic                tmo;
    logic                retire_ev;
    logic                t_load;
    logic                t_dec;
    logic                t_zero;

    assign dec_alu  = opcode inside {
        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
        OPCODE_W'(OP_AND), OPCODE_W'(OP_OR),
        OPCODE_W'(OP_XOR)};
    assign dec_mem  = opcode inside {
        OPCODE_W'(OP_LOAD), OPCODE_W'(OP_STORE)};
    assign dec_nop  = (opcode == OPCODE_W'(OP_NOP));
    assign dec_halt = (opcode == OPCODE_W'(OP_HALT));
    assign q_load   = (op_q == OPCODE_W'(OP_LOAD));
    assign q_store  = (op_q == OPCODE_W'(OP_STORE));

    seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .dec      (t_dec),
        .load_val (TMR_W'(MEM_TIMEOUT - 1)),
        .zero     (t_zero)
    );

    always_comb begin
        nxt       = state_q;
        go_fetch  = 1'b0;
        ill       = 1'b0;
        tmo       = 1'b0;
        retire_ev = 1'b0;
        t_load    = 1'b0;
        t_dec     = 1'b0;
        unique case (state_q)
            IDLE:   if (run) nxt = FETCH;
            FETCH:  nxt = DECODE;
            DECODE: begin
                unique case (1'b1)
                    dec_alu:  nxt = EXEC;
                    dec_mem: begin
                        nxt    = MEM;
                        t_load = 1'b1;
                    end
                    dec_nop: begin
                        go_fetch  = 1'b1;
                        retire_ev = 1'b1;
                    end
                    dec_halt: nxt = HALT;
                    default: begin
                        go_fetch = 1'b1;
                        ill      = 1'b1;
                    end
                endcase
            end
            EXEC:   nxt = WB;
            MEM: begin
                if (dm_ready) begin
                    if (q_load) begin
                        nxt = WB;
                    end else begin
                        go_fetch  = 1'b1;
                        retire_ev = 1'b1;
                    end
                end else if (t_zero) begin
                    go_fetch = 1'b1;
                    tmo      = 1'b1;
                end else begin
                    t_dec = 1'b1;
                end
            end
            WB: begin
                go_fetch  = 1'b1;
                retire_ev = 1'b1;
            end
            HALT:   nxt = HALT;
            default: nxt = IDLE;
        endcase
        // run is re-sampled on every FETCH entry
        if (go_fetch) nxt = run ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            state_q     <= nxt;
            err_illegal <= ill;
            err_timeout <= tmo;
            if (state_q == DECODE) op_q <= opcode;
            if (retire_ev && retired != '1) begin
                retired <= retired + RETIRE_W'(1);
            end
        end
    end

    assign state    = state_q;
    assign pc_en    = (state_q == FETCH);
    assign ir_load  = (state_q == FETCH);
    assign alu_en   = (state_q == EXEC);
    assign dm_read  = (state_q == MEM) && q_load;
    assign dm_write = (state_q == MEM) && q_store;
    assign rf_write = (state_q == WB);
    assign wb_sel   = (state_q == WB) && q_load;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected
// per-cycle snapshots, a negedge monitor pops and compares them.
module tb_control_sequencer;
    import proc_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic        pc;
        logic        ir;
        logic        alu;
        logic        dr;
        logic        dw;
        logic        rf;
        logic        wb;
        logic        hl;
        logic        ei;
        logic        et;
        logic [15:0] ret;
        logic [2:0]  rs;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        dm_ready = 1'b0;
    logic        pc_en, ir_load, alu_en, dm_read, dm_write;
    logic        rf_write, wb_sel, halted, err_illegal, err_timeout;
    logic [2:0]  state;
    logic [15:0] retired;
    logic        s_pc, s_ir, s_alu, s_dr, s_dw, s_rf, s_wb, s_hl;
    logic        s_ei, s_et;
    logic [2:0]  s_state;
    logic [2:0]  s_ret;

    int    errors = 0;
    int    checks = 0;
    int    exp_ret = 0;
    snap_t sb[$];
    string nm_q[$];

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .dm_ready(dm_ready), .pc_en(pc_en), .ir_load(ir_load),
        .alu_en(alu_en), .dm_read(dm_read), .dm_write(dm_write),
        .rf_write(rf_write), .wb_sel(wb_sel), .state(state),
        .halted(halted), .err_illegal(err_illegal),
        .err_timeout(err_timeout), .retired(retired)
    );

    control_sequencer #(.RETIRE_W(3)) u_sat (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .dm_ready(dm_ready), .pc_en(s_pc), .ir_load(s_ir),
        .alu_en(s_alu), .dm_read(s_dr), .dm_write(s_dw),
        .rf_write(s_rf), .wb_sel(s_wb), .state(s_state),
        .halted(s_hl), .err_illegal(s_ei),
        .err_timeout(s_et), .retired(s_ret)
    );

    function automatic snap_t mk(input logic [2:0] st, input logic ld,
                                 input logic ei, input logic et);
        snap_t s;
        s     = '0;
        s.st  = st;
        s.pc  = (st == FETCH);
        s.ir  = (st == FETCH);
        s.alu = (st == EXEC);
        s.dr  = (st == MEM) && ld;
        s.dw  = (st == MEM) && !ld;
        s.rf  = (st == WB);
        s.wb  = (st == WB) && ld;
        s.hl  = (st == HALT);
        s.ei  = ei;
        s.et  = et;
        s.ret = 16'(exp_ret);
        s.rs  = (exp_ret > 7) ? 3'd7 : 3'(exp_ret);
        return s;
    endfunction

    task automatic step(input logic r, input logic [3:0] op,
                        input logic rdy, input logic [2:0] st,
                        input logic ld, input logic ei,
                        input logic et, input string nm);
        run      = r;
        opcode   = op;
        dm_ready = rdy;
        @(posedge clk);
        #1;
        sb.push_back(mk(st, ld, ei, et));
        nm_q.push_back(nm);
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        #1;
        reset   = 1'b0;
        exp_ret = 0;
        #1;
        checks++;
        if (state != 3'd0 || dm_read || dm_write || halted ||
            retired != 16'd0 || s_ret != 3'd0) begin
            errors++;
            $display("FAIL %s: state=%0d rd=%b wr=%b halt=%b ret=%0d sret=%0d, want all 0",
                     nm, state, dm_read, dm_write, halted, retired, s_ret);
        end
    endtask

    initial begin : monitor
        snap_t exp_s, act_s;
        string nm;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_s = sb.pop_front();
                nm    = nm_q.pop_front();
                act_s = {state, pc_en, ir_load, alu_en, dm_read, dm_write,
                         rf_write, wb_sel, halted, err_illegal,
                         err_timeout, retired, s_ret};
                checks++;
                if (act_s !== exp_s) begin
                    errors++;
                    $display("FAIL %s: got st=%0d strb=%b ret=%0d sret=%0d, want st=%0d strb=%b ret=%0d sret=%0d",
                             nm, act_s.st, act_s[28:19], act_s.ret, act_s.rs,
                             exp_s.st, exp_s[28:19], exp_s.ret, exp_s.rs);
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 3; i++) step(0, OP_NOP, 0, IDLE, 0, 0, 0, "in_reset");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(0, OP_NOP, 1, IDLE, 0, 0, 0, "idle_run0");

        step(1, OP_ADD, 0, FETCH,  0, 0, 0, "add_fetch");
        step(1, OP_ADD, 0, DECODE, 0, 0, 0, "add_decode");
        step(1, OP_ADD, 0, EXEC,   0, 0, 0, "add_exec");
        step(1, OP_ADD, 0, WB,     0, 0, 0, "add_wb");
        exp_ret = 1;
        step(1, OP_LOAD, 0, FETCH, 0, 0, 0, "add_retire");

        step(1, OP_LOAD, 0, DECODE, 1, 0, 0, "ld_decode");
        step(1, OP_LOAD, 0, MEM,    1, 0, 0, "ld_mem1");
        step(1, OP_LOAD, 0, MEM,    1, 0, 0, "ld_mem2");
        step(1, OP_LOAD, 0, MEM,    1, 0, 0, "ld_mem3");
        step(1, OP_LOAD, 1, WB,     1, 0, 0, "ld_wb");
        exp_ret = 2;
        step(1, OP_STORE, 0, FETCH, 0, 0, 0, "ld_retire");

        step(1, OP_STORE, 0, DECODE, 0, 0, 0, "st_decode");
        step(1, OP_STORE, 0, MEM,    0, 0, 0, "st_mem");
        exp_ret = 3;
        step(1, OP_STORE, 1, FETCH,  0, 0, 0, "st_retire");

        step(1, OP_STORE, 0, DECODE, 0, 0, 0, "tmo_decode");
        step(1, OP_STORE, 0, MEM,    0, 0, 0, "tmo_mem_first");
        for (int i = 0; i < 7; i++) step(1, OP_STORE, 0, MEM, 0, 0, 0, "tmo_mem_wait");
        step(1, OP_STORE, 0, FETCH, 0, 0, 1, "tmo_abort");

        step(1, 4'd12, 0, DECODE, 0, 0, 0, "ill_decode");
        step(1, 4'd12, 0, FETCH,  0, 1, 0, "ill_pulse");
        step(1, OP_NOP, 1, DECODE, 0, 0, 0, "nop_decode");
        exp_ret = 4;
        step(1, OP_NOP, 1, FETCH, 0, 0, 0, "nop_retire");
        step(0, OP_NOP, 0, DECODE, 0, 0, 0, "nop2_decode");
        exp_ret = 5;
        step(0, OP_NOP, 0, IDLE,   0, 0, 0, "run0_divert");
        step(0, OP_HALT, 0, IDLE,  0, 0, 0, "idle_hold");

        step(1, OP_HALT, 0, FETCH,  0, 0, 0, "hlt_fetch");
        step(1, OP_HALT, 0, DECODE, 0, 0, 0, "hlt_decode");
        for (int i = 0; i < 21; i++) step(1, OP_HALT, i[0], HALT, 0, 0, 0, "halt_stay");
        async_reset("halt_async_reset");
        step(1, OP_NOP, 0, IDLE, 0, 0, 0, "halt_reset_held");
        reset = 1'b1;

        step(1, OP_NOP, 0, FETCH, 0, 0, 0, "sat_fetch");
        for (int i = 0; i < 9; i++) begin
            step(1, OP_NOP, 0, DECODE, 0, 0, 0, "sat_decode");
            exp_ret++;
            step(1, OP_NOP, 0, FETCH, 0, 0, 0, "sat_retire");
        end
        step(0, OP_NOP, 0, DECODE, 0, 0, 0, "sat_last_decode");
        exp_ret++;
        step(0, OP_NOP, 0, IDLE, 0, 0, 0, "sat_stop");

        step(1, OP_LOAD, 0, FETCH,  1, 0, 0, "rm_fetch");
        step(1, OP_LOAD, 0, DECODE, 1, 0, 0, "rm_decode");
        step(1, OP_LOAD, 0, MEM,    1, 0, 0, "rm_mem");
        async_reset("mem_async_reset");
        step(1, OP_LOAD, 1, IDLE, 0, 0, 0, "mem_reset_held");
        reset = 1'b1;
        step(0, OP_LOAD, 1, IDLE, 0, 0, 0, "post_reset_idle");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
